// File: rtl/param_fifo_if.sv
// param_fifo_if: write/read handshake, status and error signals of a param_fifo.
// The producer/consumer side uses the master modport, the FIFO itself the slave.
interface param_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             WREN;
  logic [WIDTH-1:0] DATAIN;
  logic             RDEN;
  logic             CLRERR;
  logic [WIDTH-1:0] DATAOUT;
  logic             RDVALID;
  logic             FULL;
  logic             EMPTY;
  logic             AFULL;
  logic             AEMPTY;
  logic [CW-1:0]    COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output WREN, DATAIN, RDEN, CLRERR,
    input  DATAOUT, RDVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WREN, DATAIN, RDEN, CLRERR,
    output DATAOUT, RDVALID, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO with independent push/pop in the same cycle,
// registered read data with a one-cycle valid strobe, occupancy-derived status
// flags and sticky overflow/underflow errors. Storage is not reset.
module param_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4
) (
  input  logic        CLK,
  input  logic        RESETL,
  param_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] dataout_r;
  logic             rdvalid_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             full_s;
  logic             empty_s;
  logic             afull_s;
  logic             aempty_s;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Status decode of the registered occupancy and accept decisions on pre-edge state
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    empty_s  = (count_r == {CW{1'b0}});
    afull_s  = (count_r >= CW'(AFULL_TH));
    aempty_s = (count_r <= CW'(AEMPTY_TH));
    wr_ok_s  = bus.WREN && !full_s;
    rd_ok_s  = bus.RDEN && !empty_s;
  end

  // Next occupancy: a simultaneous accepted push and pop leave it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage write; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      mem_r[wptr_r] <= bus.DATAIN;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + 1'b1;
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + 1'b1;
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered read port: data held and strobe dropped when no read is accepted
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      dataout_r <= {WIDTH{1'b0}};
      rdvalid_r <= 1'b0;
    end else if (rd_ok_s) begin
      dataout_r <= mem_r[rptr_r];
      rdvalid_r <= 1'b1;
    end else begin
      rdvalid_r <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the same cycle as CLRERR keeps the flag set
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.WREN && full_s) begin
        overflow_r <= 1'b1;
      end else if (bus.CLRERR) begin
        overflow_r <= 1'b0;
      end
      if (bus.RDEN && empty_s) begin
        underflow_r <= 1'b1;
      end else if (bus.CLRERR) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign bus.DATAOUT   = dataout_r;
  assign bus.RDVALID   = rdvalid_r;
  assign bus.COUNT     = count_r;
  assign bus.FULL      = full_s;
  assign bus.EMPTY     = empty_s;
  assign bus.AFULL     = afull_s;
  assign bus.AEMPTY    = aempty_s;
  assign bus.OVERFLOW  = overflow_r;
  assign bus.UNDERFLOW = underflow_r;
endmodule
